// File: rtl/nor_seq_pkg.sv
// Shared definitions for the NOR gate test sequencer: state encoding, vector tables,
// default energy weights. Build with NOR_SEQ_GRAY_EN to apply vectors in Gray-code order.
package nor_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } seq_state_t;

  localparam int E_IN_DEF  = 2;
  localparam int E_OUT_DEF = 3;

  // Width of the per-cycle energy increment fed to the energy accumulator
  localparam int NRG_ADD_W = 16;

  // Vector tables packed as four {a,b} pairs, entry 0 in the low bits
  localparam logic [7:0] VEC_BIN  = {2'b11, 2'b10, 2'b01, 2'b00};
  localparam logic [7:0] VEC_GRAY = {2'b10, 2'b11, 2'b01, 2'b00};

`ifdef NOR_SEQ_GRAY_EN
  localparam bit GRAY_ORDER = 1'b1;
`else
  localparam bit GRAY_ORDER = 1'b0;
`endif

  function automatic logic [1:0] vec_at(input logic [1:0] idx);
    logic [2:0] base;
    base = {idx, 1'b0};
    return GRAY_ORDER ? VEC_GRAY[base +: 2] : VEC_BIN[base +: 2];
  endfunction

  function automatic logic [1:0] bit_changes(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] d;
    d = x ^ y;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator: synchronous clear, add-enable, sticks at all-ones instead of wrapping.
module sat_accum #(
  parameter int W     = 8,
  parameter int ADD_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [ADD_W-1:0] add,
  output logic [W-1:0]     value
);

  localparam int SUM_W = ((W > ADD_W) ? W : ADD_W) + 1;
  localparam logic [SUM_W-1:0] MAX = SUM_W'({W{1'b1}});

  logic [SUM_W-1:0] sum;

  always_comb sum = SUM_W'(value) + SUM_W'(add);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      value <= '0;
    else if (clear)
      value <= '0;
    else if (en)
      value <= (sum > MAX) ? {W{1'b1}} : W'(sum);
  end

endmodule

// File: rtl/nor_test_sequencer.sv
// Sequences a 2-input NOR under test through all four vectors, checks each against the
// truth table and tracks toggles/energy. NOR_SEQ_GRAY_EN selects Gray-code vector order.
module nor_test_sequencer
  import nor_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8,
  parameter int EN_W        = 16,
  parameter int E_IN        = E_IN_DEF,
  parameter int E_OUT       = E_OUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             q_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       vec_idx,
  output logic [CNT_W-1:0] in_toggles,
  output logic [CNT_W-1:0] out_toggles,
  output logic [EN_W-1:0]  energy,
  output logic [2:0]       err_count
);

  localparam logic [7:0]           HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [NRG_ADD_W-1:0] E_IN_V    = NRG_ADD_W'(E_IN);
  localparam logic [NRG_ADD_W-1:0] E_OUT_V   = NRG_ADD_W'(E_OUT);

  seq_state_t           state;
  logic [7:0]           hold_cnt;
  logic                 q_prev;
  logic                 applying;
  logic                 sample;
  logic                 mismatch;
  logic [2:0]           err_next;
  logic [1:0]           next_vec;
  logic                 acc_clear;
  logic                 out_tog;
  logic                 in_en;
  logic [1:0]           in_bits;
  logic [NRG_ADD_W-1:0] energy_add;

  always_comb begin
    applying  = (state == S_APPLY);
    sample    = applying && (hold_cnt == HOLD_LAST);
    mismatch  = (q_in != ~(a_out | b_out));
    err_next  = err_count + {2'b00, mismatch};
    next_vec  = vec_at(vec_idx + 2'd1);
    acc_clear = (state == S_IDLE) && start;
    out_tog   = applying && (q_in != q_prev);
    in_en     = sample && (vec_idx != 2'd3);
    in_bits   = 2'd0;
    if (in_en)
      in_bits = bit_changes({a_out, b_out}, next_vec);
  end

  // A vector step and an output toggle can land on the same edge; both contribute
  always_comb begin
    energy_add = '0;
    if (in_bits[1])
      energy_add = energy_add + (E_IN_V << 1);
    if (in_bits[0])
      energy_add = energy_add + E_IN_V;
    if (out_tog)
      energy_add = energy_add + E_OUT_V;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec_idx   <= 2'd0;
      hold_cnt  <= 8'd0;
      q_prev    <= 1'b0;
      err_count <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state          <= S_APPLY;
            vec_idx        <= 2'd0;
            {a_out, b_out} <= vec_at(2'd0);
            hold_cnt       <= 8'd0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= 3'd0;
            q_prev         <= q_in;
          end
        end
        S_APPLY: begin
          hold_cnt <= hold_cnt + 8'd1;
          q_prev   <= q_in;
          if (sample) begin
            err_count <= err_next;
            if (vec_idx == 2'd3) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 3'd0);
            end else begin
              vec_idx        <= vec_idx + 2'd1;
              {a_out, b_out} <= next_vec;
              hold_cnt       <= 8'd0;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sat_accum #(.W(CNT_W), .ADD_W(2)) u_in_toggles (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .en    (in_en),
    .add   (in_bits),
    .value (in_toggles)
  );

  sat_accum #(.W(CNT_W), .ADD_W(1)) u_out_toggles (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .en    (out_tog),
    .add   (1'b1),
    .value (out_toggles)
  );

  sat_accum #(.W(EN_W), .ADD_W(NRG_ADD_W)) u_energy (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .en    (applying),
    .add   (energy_add),
    .value (energy)
  );

endmodule

// File: tb/tb_nor_test_sequencer.sv
// Bench for nor_test_sequencer: per-cycle model of the sequence rules plus directed scenarios.
// A second, narrow instance (CNT_W=2, EN_W=3) driven by a free-toggling q_in exercises saturation.
module tb_nor_test_sequencer;

  localparam int H     = 4;
  localparam int LAST  = 4 * H;
  localparam int E_IN  = 2;
  localparam int E_OUT = 3;

`ifdef NOR_SEQ_GRAY_EN
  localparam int EXP_IN    = 3;
  localparam int NOR_E     = 9;
  localparam int C0_E      = 6;
  localparam int AND_OUT   = 2;
  localparam int AND_E     = 12;
`else
  localparam int EXP_IN    = 4;
  localparam int NOR_E     = 11;
  localparam int C0_E      = 8;
  localparam int AND_OUT   = 1;
  localparam int AND_E     = 11;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  int         gate_sel;
  logic       q_main;
  logic       q_small;

  logic       a_out, b_out, busy, done, pass;
  logic [1:0] vec_idx;
  logic [7:0] in_toggles, out_toggles;
  logic [15:0] energy;
  logic [2:0] err_count;

  logic       a_s, b_s, busy_s, done_s, pass_s;
  logic [1:0] vec_s;
  logic [1:0] in_s, out_s;
  logic [2:0] energy_s;
  logic [2:0] err_s;
  logic       unused_small;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit checking     = 1'b0;

  bit         m_valid = 1'b0;
  int         m_k     = 0;
  int         m_sel   = 0;
  logic [1:0] m_prev  = 2'b00;

  always #5 clk = ~clk;

  function automatic logic [1:0] vec_of(input int j);
`ifdef NOR_SEQ_GRAY_EN
    return 2'(j ^ (j >> 1));
`else
    return 2'(j);
`endif
  endfunction

  function automatic logic gate_of(input int sel, input logic [1:0] ab);
    case (sel)
      0:       return ~(ab[1] | ab[0]);
      1:       return 1'b0;
      default: return ab[1] & ab[0];
    endcase
  endfunction

  function automatic int ham(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] d;
    d = x ^ y;
    return int'(d[1]) + int'(d[0]);
  endfunction

  function automatic logic q_at(input int c, input int sel, input logic [1:0] prev);
    if (c == 0)
      return gate_of(sel, prev);
    return gate_of(sel, vec_of((c - 1) / H));
  endfunction

  function automatic int min_i(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  assign q_main = gate_of(gate_sel, {a_out, b_out});
  assign unused_small = ^{err_s, pass_s};

  nor_test_sequencer #(.HOLD_CYCLES(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .q_in        (q_main),
    .a_out       (a_out),
    .b_out       (b_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .vec_idx     (vec_idx),
    .in_toggles  (in_toggles),
    .out_toggles (out_toggles),
    .energy      (energy),
    .err_count   (err_count)
  );

  nor_test_sequencer #(.HOLD_CYCLES(H), .CNT_W(2), .EN_W(3)) dut_small (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .q_in        (q_small),
    .a_out       (a_s),
    .b_out       (b_s),
    .busy        (busy_s),
    .done        (done_s),
    .pass        (pass_s),
    .vec_idx     (vec_s),
    .in_toggles  (in_s),
    .out_toggles (out_s),
    .energy      (energy_s),
    .err_count   (err_s)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Model timeline: m_k is the cycle number counted from the edge that accepted start
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_k     = 0;
    end else if (start && (!m_valid || m_k >= LAST + 2)) begin
      m_prev  = m_valid ? vec_of(3) : 2'b00;
      m_sel   = gate_sel;
      m_valid = 1'b1;
      m_k     = 1;
    end else if (m_valid && m_k < 100000) begin
      m_k++;
    end
  end

  always @(negedge clk) begin
    int n, in_raw, out_raw, errs, ev, j;
    int e_busy, e_done, e_pass, e_vec;
    logic [1:0] e_ab;
    if (checking) begin
      in_raw = 0; out_raw = 0; errs = 0; n = 0;
      e_busy = 0; e_done = 0; e_pass = 0; e_vec = 0; e_ab = 2'b00;
      if (m_valid) begin
        n = min_i(m_k - 1, LAST);
        for (int e = 1; e <= n; e++) begin
          if (q_at(e, m_sel, m_prev) != q_at(e - 1, m_sel, m_prev))
            out_raw++;
          if (e % H == 0) begin
            j = e / H;
            if (gate_of(m_sel, vec_of(j - 1)) != gate_of(0, vec_of(j - 1)))
              errs++;
            if (j < 4)
              in_raw += ham(vec_of(j - 1), vec_of(j));
          end
        end
        e_busy = (m_k <= LAST) ? 1 : 0;
        e_done = (m_k == LAST + 1) ? 1 : 0;
        e_vec  = (m_k <= LAST) ? (m_k - 1) / H : 3;
        e_pass = (m_k > LAST && errs == 0) ? 1 : 0;
        e_ab   = vec_of(e_vec);
      end
      ev = E_IN * in_raw + E_OUT * out_raw;
      check_output("cyc_busy", busy, e_busy);
      check_output("cyc_done", done, e_done);
      check_output("cyc_pass", pass, e_pass);
      check_output("cyc_vec_idx", vec_idx, e_vec);
      check_output("cyc_a", a_out, e_ab[1]);
      check_output("cyc_b", b_out, e_ab[0]);
      check_output("cyc_in_toggles", in_toggles, min_i(in_raw, 255));
      check_output("cyc_out_toggles", out_toggles, min_i(out_raw, 255));
      check_output("cyc_energy", energy, min_i(ev, 65535));
      check_output("cyc_err_count", err_count, errs);
      check_output("sm_busy", busy_s, e_busy);
      check_output("sm_done", done_s, e_done);
      check_output("sm_vec_idx", vec_s, e_vec);
      check_output("sm_ab", {a_s, b_s}, e_ab);
      check_output("sm_in_toggles", in_s, min_i(in_raw, 3));
      check_output("sm_out_toggles", out_s, min_i(n, 3));
      check_output("sm_energy", energy_s, min_i(E_IN * in_raw + E_OUT * n, 7));
    end
  end

  initial begin
    q_small = 1'b0;
    forever begin
      @(posedge clk);
      #2 q_small = ~q_small;
    end
  end

  task automatic apply_stimulus(input int sel, input bit mid_start, output int lat, output int busy_n);
    bit got;
    int cyc;
    gate_sel = sel;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    got = 1'b0; cyc = 0; busy_n = 0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (done) got = 1'b1;
      if (mid_start && cyc == 6) start = 1'b1;
      if (mid_start && cyc == 7) start = 1'b0;
    end
    lat = got ? cyc : -1;
    if (!got) check_output("done_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
  endtask

  initial begin
    int lat, bn, cyc;
    bit done_seen;
    reset = 1'b0; start = 1'b0; gate_sel = 0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    checking = 1'b1;

    @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_pass", pass, 0);
    check_output("rst_ab", {a_out, b_out}, 0);
    check_output("rst_energy", energy, 0);

    $display("[TB] ideal NOR");
    apply_stimulus(0, 1'b0, lat, bn);
    check_output("nor_latency", lat, 17);
    check_output("nor_busy_cycles", bn, 16);
    check_output("nor_err", err_count, 0);
    check_output("nor_pass", pass, 1);
    check_output("nor_in", in_toggles, EXP_IN);
    check_output("nor_out", out_toggles, 1);
    check_output("nor_energy", energy, NOR_E);
    check_output("sat_out", out_s, 3);
    check_output("sat_energy", energy_s, 7);

    $display("[TB] q_in stuck at 0");
    pulse_reset();
    apply_stimulus(1, 1'b0, lat, bn);
    check_output("c0_err", err_count, 1);
    check_output("c0_pass", pass, 0);
    check_output("c0_out", out_toggles, 0);
    check_output("c0_energy", energy, C0_E);

    $display("[TB] AND gate");
    pulse_reset();
    apply_stimulus(2, 1'b0, lat, bn);
    check_output("and_err", err_count, 2);
    check_output("and_pass", pass, 0);
    check_output("and_out", out_toggles, AND_OUT);
    check_output("and_energy", energy, AND_E);

    $display("[TB] start while busy");
    pulse_reset();
    apply_stimulus(0, 1'b1, lat, bn);
    check_output("mid_latency", lat, 17);
    check_output("mid_busy_cycles", bn, 16);
    check_output("mid_in", in_toggles, EXP_IN);
    check_output("mid_out", out_toggles, 1);
    check_output("mid_energy", energy, NOR_E);

    $display("[TB] reset during vector 2");
    gate_sel = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cyc = 0;
    while (vec_idx != 2'd2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_output("reach_vec2", vec_idx, 2);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check_output("mr_busy", busy, 0);
    check_output("mr_done", done, 0);
    check_output("mr_vec_idx", vec_idx, 0);
    check_output("mr_ab", {a_out, b_out}, 0);
    check_output("mr_in", in_toggles, 0);
    check_output("mr_out", out_toggles, 0);
    check_output("mr_energy", energy, 0);
    check_output("mr_err", err_count, 0);
    @(posedge clk); #2 reset = 1'b0;
    done_seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check_output("mr_no_done", done_seen, 0);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/nor_test_sequencer.md
Name: nor_test_sequencer

Overview:
Clocked controller that sequences a 2-input NOR gate under test through all four input vectors.
- Holds each vector for a programmable number of cycles.
- Samples the gate output and checks it against the NOR truth table.
- Counts input and output transitions and accumulates an energy estimate.
- Replaces hand-written delay-based stimulus with a self-checking, start/done-handshaked sequencer in the gate test benches.

Parameters:
- HOLD_CYCLES, 4: cycles each vector is held; legal range 2..255.
- CNT_W, 8: width of the toggle counters.
- EN_W, 16: width of the energy accumulator.
- E_IN, 2: energy units added per input-bit toggle.
- E_OUT, 3: energy units added per output toggle.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a sequence; sampled only in IDLE.
- q_in  input  1  output of the gate under test (combinational from a_out/b_out).
- a_out  output  1  gate input A.
- b_out  output  1  gate input B.
- busy  output  1  high while a sequence runs.
- done  output  1  one-cycle pulse at sequence end.
- pass  output  1  high when the last sequence had zero mismatches; valid from done onward.
- vec_idx  output  2  index of the vector currently applied.
- in_toggles  output  CNT_W  count of a_out/b_out bit transitions.
- out_toggles  output  CNT_W  count of q_in transitions.
- energy  output  EN_W  E_IN*in_toggles + E_OUT*out_toggles, saturating.
- err_count  output  3  number of vectors whose sample mismatched.

Behaviour:
- Reset (async assert, sync-released):
  - State IDLE.
  - a_out, b_out, busy, done, pass, vec_idx, counters, energy and err_count all 0.
- States: IDLE, APPLY, DONE.
- IDLE & start:
  - Next edge: state APPLY, vec_idx=0, a/b = vector 0, hold_cnt=0, busy=1.
  - Clear in_toggles, out_toggles, energy and err_count.
  - Load q_prev with q_in.
- APPLY, every cycle:
  - hold_cnt increments.
  - If q_in != q_prev: out_toggles++ and energy += E_OUT.
  - q_prev <= q_in.
- APPLY, cycle where hold_cnt == HOLD_CYCLES-1 (sample cycle):
  - Compare q_in with ~(a_out|b_out); on mismatch err_count++.
  - If vec_idx==3: go to DONE.
  - Else: vec_idx++, drive the next vector, hold_cnt=0, and add the number of changed a/b bits to in_toggles (energy += E_IN per bit).
- Vector order (default, binary): 00, 01, 10, 11 as {a,b}.
- DONE (one cycle):
  - done=1, busy=0, pass=(err_count==0).
  - Next edge: IDLE with done=0.
  - a_out/b_out keep the last vector.
  - Results hold until the next start.
- Latency: start sampled -> done asserted = 4*HOLD_CYCLES+1 cycles; busy is high for exactly 4*HOLD_CYCLES cycles.
- start while busy or in DONE is ignored; no queuing.
- Counters and energy saturate at all-ones; they never wrap.
- Simultaneous sample-cycle mismatch and output toggle: both are recorded in the same cycle.
- Reset mid-sequence: immediate return to reset values; the partial sequence is discarded.

Optional Feature:
- Macro NOR_SEQ_GRAY_EN.
- Defined: vector order is Gray code 00, 01, 11, 10, so exactly one input bit changes per step; the ideal in_toggles is 3.
- Undefined: binary order as above; the ideal in_toggles is 4.
- All other behaviour is identical.

Decomposition:
- Shared package nor_seq_pkg:
  - State encoding constants (IDLE=2'd0, APPLY=2'd1, DONE=2'd2).
  - Vector tables for both orders.
  - Default E_IN/E_OUT constants.
- Sub-module sat_accum: a saturating accumulator with clear, add-enable and a width parameter, instantiated for in_toggles, out_toggles and energy.

Test Plan:
- Ideal NOR as DUT, binary order, HOLD_CYCLES=4, start pulse -> busy for 16 cycles, done pulse on cycle 17; err_count=0, pass=1, in_toggles=4, out_toggles=1, energy=11.
- Same bench built with NOR_SEQ_GRAY_EN -> in_toggles=3, out_toggles=1, energy=9, pass=1.
- q_in tied to 0 -> err_count=1 (vector 00), pass=0, out_toggles=0, energy=8.
- AND gate as DUT -> err_count=2 (vectors 00 and 11), pass=0, out_toggles=1.
- start pulsed again mid-sequence -> ignored; total latency and counts unchanged. Then assert reset at vector 2 -> all outputs 0 immediately, busy=0, no done pulse.
- Small EN_W=3, CNT_W=2 build with a DUT output toggling every cycle -> out_toggles saturates at 3 and energy saturates at 7, with no wrap.
